data_mem_responder: RTL

Word-addressed data-memory responder for the processor's load/store port: the memory-side end of the processor's request/response data-memory interface.
- Accepts one request at a time over a valid/ready handshake.
- Holds it for a fixed, parameterised wait-state latency, then commits writes or reads data and returns a one-cycle response pulse.
- Lets the processor core be exercised against a realistic, non-zero-latency memory instead of a combinational array.

---
 rtl/mem_if_pkg.sv | 21 ++
 rtl/data_mem_responder_if.sv | 29 ++
 rtl/word_ram.sv | 38 +++
 rtl/data_mem_responder.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and helpers for the data-memory responder and its bench.
//   state_t      : responder control states
//   DATA_W       : data word width
//   CNT_W        : width of the wait-state down-counter (LATENCY up to 15)
//   word_aligned : true when a byte address selects a whole 32-bit word
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request/response bundle between processor and data memory.
//   req_valid/req_ready : request handshake (accept when both high at a clock edge)
//   req_we, req_addr, req_wdata : request payload (store flag, byte address, store data)
//   resp_valid, resp_rdata, resp_err : one-cycle response pulse with load data / error flag
//   busy : a request is in flight
// master = processor side, slave = memory responder side.
interface data_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/word_ram.sv
// Single-port DEPTH_WORDS x 32 word store with synchronous write and a
// registered read taken on an enable strobe. Contents are never reset.
//   clock   : rising-edge clock
//   i_we    : write strobe, writes i_wdata to word i_idx
//   i_re    : read strobe, loads o_rdata from word i_idx
//   i_idx   : word index
//   i_wdata : write data
//   o_rdata : registered read data (holds between read strobes)
module word_ram
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = 6
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Power-up contents are zero; reset deliberately leaves them alone.
  logic [DATA_W-1:0] r_mem [DEPTH_WORDS] = '{default: '0};
  logic [DATA_W-1:0] r_rdata = '0;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder for the processor load/store port.
// Accepts one request at a time, holds it for LATENCY clock edges, then
// commits the store or reads the word and emits a one-cycle response.
//   clock : system clock, rising edge
//   reset : synchronous, active-high; drops any in-flight request
//   bus   : slave end of data_mem_responder_if (request/response signals, busy)
//
// state | meaning
// IDLE  | ready for a request, no response pending
// WAIT  | request captured, counting wait states down to the commit edge
// RESP  | response pulse cycle; a new request may be accepted here
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L  = ADDR_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic              r_err;
  logic              r_rd_ok;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_wdata;

  logic              w_accept;
  logic              w_commit;
  logic [ADDR_W-1:0] w_word;
  logic              w_req_err;
  logic [DATA_W-1:0] w_ram_rdata;

  // Full upper address is compared against the depth so high bits never alias.
  assign w_word    = {2'b00, bus.req_addr[ADDR_W-1:2]};
  assign w_req_err = !word_aligned(bus.req_addr[1:0]) || (w_word >= DEPTH_L);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= CNT_LOAD;
        r_we    <= bus.req_we;
        r_err   <= w_req_err;
        r_idx   <= bus.req_addr[IDX_W+1:2];
        r_wdata <= bus.req_wdata;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_rd_ok <= !r_we && !r_err;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_commit       = 1'b0;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end
      end
      WAIT: begin
        bus.busy = 1'b1;
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = RESP;
        end
      end
      RESP: begin
        bus.req_ready  = 1'b1;
        bus.resp_valid = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Store strobe is gated by reset so a reset on the commit edge drops the write.
  word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_commit && r_we && !r_err && !reset),
    .i_re    (w_commit && !r_we && !r_err),
    .i_idx   (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // RAM read register is not reset, so the outputs are qualified by state.
  assign bus.resp_rdata = (r_state == RESP && r_rd_ok) ? w_ram_rdata : '0;
  assign bus.resp_err   = (r_state == RESP) && r_err;

endmodule
